// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage -- BlueberryV instruction fetch stage.
//
// Owns the PC. Issues at most one outstanding read to instruction memory over
// a request/grant/response handshake. Delivers instructions to decode through
// the DE_* output register. A one-entry buffer holds a response that arrives
// while decode is stalled, so no fetch is lost or duplicated. Execute-stage
// redirects flush the output, the buffer and any in-flight response.
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   defined   : a redirect to a target that is not word aligned sets the
//               sticky FE_MISALIGN flag and parks the block in HALT until RST.
//   undefined : no FE_MISALIGN port; redirect targets are forced to word
//               alignment.
//
// Ports:
//   CLK          clock, rising edge
//   RST          synchronous active-high reset
//   IM_REQ       instruction memory request valid
//   IM_ADDR      request address (the PC register)
//   IM_GNT       memory accepted the request this cycle
//   IM_RVALID    response valid
//   IM_RDATA     returned instruction word
//   DE_STALL     decode cannot accept; DE_* hold
//   BR_TAKEN     redirect request from execute
//   BR_TARGET    redirect address
//   DE_V         DE_IR/DE_PC hold a valid instruction
//   DE_IR        instruction to decode
//   DE_PC        address of DE_IR
//   FE_MISALIGN  sticky misaligned-redirect flag (macro builds only)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h1000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IM_REQ,
  output logic [15:0] IM_ADDR,
  input  logic        IM_GNT,
  input  logic        IM_RVALID,
  input  logic [31:0] IM_RDATA,
  input  logic        DE_STALL,
  input  logic        BR_TAKEN,
  input  logic [15:0] BR_TARGET,
  output logic        DE_V,
  output logic [31:0] DE_IR,
  output logic [15:0] DE_PC
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        FE_MISALIGN
`endif
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    S_HALT  = 3'd4
`endif
  } state_t;

  state_t          state;
  logic [AW-1:0]   pc;
  logic [AW-1:0]   req_pc;
  logic            buf_v;
  logic [DW-1:0]   buf_ir;
  logic [AW-1:0]   buf_pc;
  logic            de_v;
  logic [DW-1:0]   de_ir;
  logic [AW-1:0]   de_pc;
  state_t          br_state_c;
  logic            br_active_c;
  logic            br_misalign_c;
`ifdef FETCH_MISALIGN_CHK_EN
  logic            misalign;
`endif

  // Request is a decode of the state register, forced low during reset.
  assign IM_REQ  = (state == S_REQ) && !RST;
  assign IM_ADDR = pc;
  assign DE_V    = de_v;
  assign DE_IR   = de_ir;
  assign DE_PC   = de_pc;
`ifdef FETCH_MISALIGN_CHK_EN
  assign FE_MISALIGN = misalign;
`endif

  // Where a redirect lands, depending on whether a request is in flight.
  always_comb begin
    br_state_c = S_REQ;
    case (state)
      S_REQ:   br_state_c = IM_GNT    ? S_DRAIN : S_REQ;
      S_WAIT:  br_state_c = IM_RVALID ? S_REQ   : S_DRAIN;
      S_HOLD:  br_state_c = S_REQ;
      S_DRAIN: br_state_c = IM_RVALID ? S_REQ   : S_DRAIN;
      default: br_state_c = S_REQ;
    endcase
  end

  // A halted block ignores redirects; only reset brings it back.
`ifdef FETCH_MISALIGN_CHK_EN
  assign br_active_c   = BR_TAKEN && (state != S_HALT);
  assign br_misalign_c = (BR_TARGET[1:0] != 2'b00);
`else
  assign br_active_c   = BR_TAKEN;
  assign br_misalign_c = 1'b0;
`endif

  // Fetch control, PC, buffer and decode output register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      req_pc <= '0;
      buf_v  <= 1'b0;
      buf_ir <= NOP;
      buf_pc <= '0;
      de_v   <= 1'b0;
      de_ir  <= NOP;
      de_pc  <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign <= 1'b0;
`endif
    end else if (br_active_c) begin
      // Redirect flushes everything younger than execute, stall or not.
      de_v  <= 1'b0;
      buf_v <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      pc <= BR_TARGET;
      if (br_misalign_c) begin
        misalign <= 1'b1;
        state    <= S_HALT;
      end else begin
        state <= br_state_c;
      end
`else
      pc    <= BR_TARGET & ~AW'(3);
      state <= br_state_c;
`endif
    end else begin
      case (state)
        S_REQ: begin
          if (!DE_STALL) de_v <= 1'b0;
          if (IM_GNT) begin
            req_pc <= pc;
            pc     <= pc + AW'(4);
            state  <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (IM_RVALID) begin
            if (!DE_STALL) begin
              de_v  <= 1'b1;
              de_ir <= IM_RDATA;
              de_pc <= req_pc;
              state <= S_REQ;
            end else begin
              buf_v  <= 1'b1;
              buf_ir <= IM_RDATA;
              buf_pc <= req_pc;
              state  <= S_HOLD;
            end
          end else if (!DE_STALL) begin
            de_v <= 1'b0;
          end
        end

        // Buffered instruction waits here; no new request until it leaves.
        S_HOLD: begin
          if (!DE_STALL) begin
            de_v  <= buf_v;
            de_ir <= buf_ir;
            de_pc <= buf_pc;
            buf_v <= 1'b0;
            state <= S_REQ;
          end
        end

        // The in-flight response belongs to a flushed path: swallow it.
        S_DRAIN: begin
          if (!DE_STALL) de_v <= 1'b0;
          if (IM_RVALID) state <= S_REQ;
        end

`ifdef FETCH_MISALIGN_CHK_EN
        S_HALT: begin
          de_v <= 1'b0;
        end
`endif

        default: state <= S_REQ;
      endcase
    end
  end

  // Only consulted in macro builds; keeps the default build free of dangling logic.
  logic unused_c;
  assign unused_c = br_misalign_c;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the BlueberryV pipeline, sitting upstream of `decode_stage`. It owns the PC and issues one-outstanding-request reads to instruction memory over a request/grant/response handshake. It delivers `DE_V`/`DE_IR`/`DE_PC` to decode, honouring decode stalls and execute-stage branch redirects, and buffers one returned instruction so no fetch is lost or duplicated under stall.

## Interface
Parameters:
- `RESET_PC`, 16'h1000, first fetch address after reset; must be word aligned.

Ports:
- `CLK`  in  1  clock; all logic is on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `IM_REQ`  out  1  instruction memory request valid.
- `IM_ADDR`  out  16  request address; always equals the PC register.
- `IM_GNT`  in  1  memory accepted the request this cycle (meaningful only while `IM_REQ`=1).
- `IM_RVALID`  in  1  response data valid.
- `IM_RDATA`  in  32  returned instruction word.
- `DE_STALL`  in  1  decode cannot accept; `DE_*` must hold.
- `BR_TAKEN`  in  1  redirect request from execute.
- `BR_TARGET`  in  16  redirect address.
- `DE_V`  out  1  `DE_IR`/`DE_PC` hold a valid instruction.
- `DE_IR`  out  32  instruction to decode.
- `DE_PC`  out  16  address of `DE_IR`.
- `FE_MISALIGN`  out  1  sticky misaligned-redirect flag; present only with `FETCH_MISALIGN_CHK_EN`.

## Operation
- Registers: `PC` (next fetch address), `REQ_PC` (address of the outstanding request), 1-entry buffer `BUF_V`/`BUF_IR`/`BUF_PC`, output register `DE_*`, and state.
- States:
  - `REQ`: `IM_REQ`=1. On `IM_GNT`, `REQ_PC`<=`PC`, `PC`<=`PC`+4 (16-bit wrap, 0xFFFC+4=0x0000), then go to `WAIT`. `IM_RVALID` is ignored in `REQ`.
  - `WAIT`: `IM_REQ`=0. On `IM_RVALID`:
    - If `DE_STALL`=0: `DE_*`<=`{1, IM_RDATA, REQ_PC}`, then go to `REQ`.
    - Else: capture into the buffer, then go to `HOLD`.
  - `HOLD`: `IM_REQ`=0. When `DE_STALL`=0, the buffer moves to `DE_*`, `BUF_V`<=0, then go to `REQ`.
  - `DRAIN`: a granted request belongs to a flushed path. Discard the next `IM_RVALID`, then go to `REQ`.
  - `HALT`: exists only with the macro. No requests are issued; the block exits only on `RST`.
- `DE_*` update rule:
  - When `DE_STALL`=0 and nothing new is delivered, `DE_V`<=0 (bubble).
  - When `DE_STALL`=1, `DE_*` hold.
- Redirect (`BR_TAKEN`=1) has priority over everything except `RST`, and overrides `DE_STALL`:
  - `PC`<=`BR_TARGET`, `DE_V`<=0, `BUF_V`<=0.
  - Next state by current state:
    - `REQ` with `IM_GNT`=1 (old address accepted): `DRAIN`.
    - `REQ` with `IM_GNT`=0: `REQ`, with the new address next cycle. This is the only case where `IM_ADDR` may change before grant.
    - `WAIT` without `IM_RVALID`: `DRAIN`.
    - `WAIT` with `IM_RVALID`: the response is dropped; go to `REQ`.
    - `HOLD` or `DRAIN` with `IM_RVALID`: `REQ`.
    - `DRAIN` without `IM_RVALID`: stay in `DRAIN`.
- Aside from the redirect exception, `IM_ADDR` is stable from `IM_REQ` rise until grant.

## Timing
- Reset values: state `REQ`, `PC`=`RESET_PC`, `REQ_PC`=0, `BUF_V`=0, `DE_V`=0, `DE_IR`=32'h00000013 (NOP), `DE_PC`=16'h0000, `FE_MISALIGN`=0.
- `IM_REQ` is 0 while `RST`=1. `IM_REQ`=1 with `IM_ADDR`=`RESET_PC` in the first cycle after `RST` falls.
- Latency: `IM_RVALID` in cycle N with no stall gives `DE_V`=1 in N+1.
- Best-case throughput: one instruction per 2 cycles (grant in cycle N, response in N+1, next request in N+2).
- Reset mid-operation: all state returns to the reset values next cycle. Any late `IM_RVALID` is ignored because the block is in `REQ`.
- `IM_RVALID` in the same cycle as grant is not supported; memory responds at least 1 cycle after grant.

## Configuration
- `FETCH_MISALIGN_CHK_EN` defined:
  - A redirect with `BR_TARGET[1:0]`!=0 sets `FE_MISALIGN`<=1 (sticky), `DE_V`<=0, and moves to `HALT`.
  - If a request was granted, the response is still discarded in `HALT`.
- Not defined:
  - No `FE_MISALIGN` port and no `HALT` state.
  - `PC`<={`BR_TARGET[15:2]`,2'b00}.

## Test plan
- Reset release, `IM_GNT`=1, response 1 cycle after grant with data 0x00500093, then 0xFFF2A183 → `DE_PC`=0x1000 with `DE_IR`=0x00500093, then `DE_PC`=0x1004 with 0xFFF2A183; `DE_V` pulses every 2 cycles.
- `DE_STALL`=1 for 3 cycles spanning the 0x1004 response → `DE_*` hold 0x1000; 0x1004 appears the cycle after the stall drops, exactly once; no request is issued in `HOLD`.
- `IM_GNT` held 0 for 4 cycles → `IM_REQ`=1 and `IM_ADDR`=0x1000 stable for all 4 cycles; `PC` advances only on the grant.
- `BR_TAKEN` with `BR_TARGET`=0x2000 while the 0x1008 request is in `WAIT` → the 0x1008 response is discarded, `DE_V`=0 until an instruction with `DE_PC`=0x2000 is delivered.
- `RST` pulse while in `WAIT`, then `IM_RVALID` arrives 1 cycle after reset falls → the response is ignored; outputs show the reset values; the first request goes to 0x1000.
- `BR_TARGET`=0x2002:
  - With the macro: `FE_MISALIGN`=1 and `IM_REQ` stays 0 until `RST`.
  - Without the macro: the next request goes to 0x2000.
